// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

   // Default divisor/remainder width; dividend and quotient are twice this.
   localparam int DIV_N = 4;

   // Iteration counter must hold the values 0 .. 2N inclusive.
   localparam int DIV_CNT_W = $clog2(2 * DIV_N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Counter width for an arbitrary divisor width n.
   function automatic int cnt_width(input int n);
      return $clog2(2 * n + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, the caller decides when to use the result.
module div_step
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic [N:0]   prem_i,
   input  logic [N-1:0] divisor_i,
   output logic [N:0]   prem_o,
   output logic         q_bit_o
);

   logic [N+1:0] diff;

   // Borrow out of the (N+1)-bit subtraction means the divisor did not fit: keep the old value.
   always_comb begin
      diff    = {1'b0, prem_i} - {2'b00, divisor_i};
      q_bit_o = ~diff[N+1];
      prem_o  = diff[N+1] ? prem_i : diff[N:0];
   end

endmodule

// File: rtl/sequential_divider.sv
// Unsigned 2N/N restoring divider, one quotient bit per clock through a single shared subtract stage.
// Latency: done pulses in the cycle after the (2N+2)-th edge counted from the start edge; divide-by-zero finishes on the next cycle.
// Backpressure: none; start is only sampled in IDLE and ignored while busy, done is a single-cycle pulse.
module sequential_divider
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic [2*N-1:0] quotient,
   output logic [N-1:0]   remainder,
   output logic           busy,
   output logic           done,
   output logic           div_by_zero
);

   localparam int            CW        = cnt_width(N);
   localparam logic [CW-1:0] LAST_ITER = CW'(2 * N);

   div_state_e     state_q, state_d;
   logic [N-1:0]   divisor_q, divisor_d;
   logic [2*N-1:0] sreg_q, sreg_d;
   logic [N:0]     prem_q, prem_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           dbz_q, dbz_d;

   logic [N:0]     step_in;
   logic [N:0]     step_rem;
   logic           step_qbit;

   // The partial remainder is always below the divisor, so its top bit is zero and
   // the shifted value {prem[N-1:0], dividend msb} still fits in N+1 bits.
   assign step_in = {prem_q[N-1:0], sreg_q[2*N-1]};

   div_step #(.N(N)) u_step (
      .prem_i    (step_in),
      .divisor_i (divisor_q),
      .prem_o    (step_rem),
      .q_bit_o   (step_qbit)
   );

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         divisor_q <= '0;
         sreg_q    <= '0;
         prem_q    <= '0;
         cnt_q     <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         divisor_q <= divisor_d;
         sreg_q    <= sreg_d;
         prem_q    <= prem_d;
         cnt_q     <= cnt_d;
         dbz_q     <= dbz_d;
      end
   end

   // Next state: zero divisor skips RUN; RUN spends one extra cycle after the last iteration before DONE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: load on an accepted start, then shift one quotient bit in per RUN cycle until 2N are done.
   always_comb begin
      divisor_d = divisor_q;
      sreg_d    = sreg_q;
      prem_d    = prem_q;
      cnt_d     = cnt_q;
      dbz_d     = dbz_q;
      if (state_q == IDLE && start) begin
         cnt_d = '0;
         if (divisor == '0) begin
            sreg_d = '1;
            prem_d = {1'b0, dividend[N-1:0]};
            dbz_d  = 1'b1;
         end else begin
            divisor_d = divisor;
            sreg_d    = dividend;
            prem_d    = '0;
            dbz_d     = 1'b0;
         end
      end else if (state_q == RUN && cnt_q != LAST_ITER) begin
         sreg_d = {sreg_q[2*N-2:0], step_qbit};
         prem_d = step_rem;
         cnt_d  = cnt_q + CW'(1);
      end
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         IDLE:    busy = 1'b0;
         RUN:     busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   assign quotient    = sreg_q;
   assign remainder   = prem_q[N-1:0];
   assign div_by_zero = dbz_q;

   // The stored partial remainder never reaches 2^N; a set top bit means a broken step.
   prem_top_clear: assert property (@(posedge clk) disable iff (!rst_n) prem_q[N] == 1'b0);

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: arithmetic/timing model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_sequential_divider;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic [2*N-1:0] quotient;
   logic [N-1:0]   remainder;
   logic           busy;
   logic           done;
   logic           div_by_zero;

   int checks   = 0;
   int failures = 0;

   sequential_divider #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_t: cycles since the accepting edge (-1 when idle); done is due when m_t == m_len.
   int             m_t   = -1;
   int             m_len = 0;
   logic [2*N-1:0] m_q   = '0;
   logic [N-1:0]   m_r   = '0;
   logic           m_dbz = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_t   = -1;
         m_q   = '0;
         m_r   = '0;
         m_dbz = 1'b0;
      end else if (m_t < 0) begin
         if (start) begin
            m_t = 0;
            if (divisor == '0) begin
               m_len = 0;
               m_q   = '1;
               m_r   = dividend[N-1:0];
               m_dbz = 1'b1;
            end else begin
               m_len = 2 * N + 1;
               m_q   = dividend / {4'b0000, divisor};
               m_r   = N'(dividend % {4'b0000, divisor});
               m_dbz = 1'b0;
            end
         end
      end else if (m_t == m_len) begin
         m_t = -1;
      end else begin
         m_t = m_t + 1;
      end
   end

   // Compare every cycle; results are only meaningful in idle or in the done cycle.
   always @(negedge clk) begin
      if (rst_n !== 1'bx) begin
         chk("model_busy", int'(busy), int'(m_t >= 0));
         chk("model_done", int'(done), int'(m_t >= 0 && m_t == m_len));
         chk("model_dbz", int'(div_by_zero), int'(m_dbz));
         if (m_t < 0 || m_t == m_len) begin
            chk("model_quotient", int'(quotient), int'(m_q));
            chk("model_remainder", int'(remainder), int'(m_r));
         end
      end
   end

   // ---------------- stimulus ----------------
   // Pulse start for one cycle, scramble the inputs afterwards, and wait for done.
   // lat counts edges from the start edge through the edge that enters DONE.
   task automatic run_op(input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                         output int lat, output int run_cycles);
      @(negedge clk);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(negedge clk);
      start      = 1'b0;
      dividend   = (2*N)'($urandom);
      divisor    = N'($urandom);
      lat        = 1;
      run_cycles = 0;
      while (!done && lat < 40) begin
         if (busy) run_cycles++;
         @(negedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, rc, ndone, first, second;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      chk("reset_quotient", int'(quotient), 0);
      chk("reset_remainder", int'(remainder), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_dbz", int'(div_by_zero), 0);
      rst_n = 1'b1;

      // 200 / 7 = 28 rem 4, nine RUN cycles before DONE
      run_op(8'd200, 4'd7, lat, rc);
      chk("200/7 latency", lat, 10);
      chk("200/7 run_cycles", rc, 9);
      chk("200/7 quotient", int'(quotient), 28);
      chk("200/7 remainder", int'(remainder), 4);
      chk("200/7 dbz", int'(div_by_zero), 0);
      @(negedge clk);
      chk("200/7 done_is_pulse", int'(done), 0);
      chk("200/7 held_quotient", int'(quotient), 28);

      run_op(8'd255, 4'd1, lat, rc);
      chk("255/1 quotient", int'(quotient), 255);
      chk("255/1 remainder", int'(remainder), 0);
      run_op(8'd255, 4'd15, lat, rc);
      chk("255/15 quotient", int'(quotient), 17);
      chk("255/15 remainder", int'(remainder), 0);
      run_op(8'd0, 4'd5, lat, rc);
      chk("0/5 quotient", int'(quotient), 0);
      chk("0/5 remainder", int'(remainder), 0);

      // divide by zero: no RUN cycles, low dividend bits returned as remainder
      run_op(8'd100, 4'd0, lat, rc);
      chk("100/0 latency", lat, 1);
      chk("100/0 quotient", int'(quotient), 255);
      chk("100/0 remainder", int'(remainder), 4);
      chk("100/0 dbz", int'(div_by_zero), 1);
      @(negedge clk);
      chk("100/0 dbz_held", int'(div_by_zero), 1);
      run_op(8'd9, 4'd2, lat, rc);
      chk("after_dbz dbz_cleared", int'(div_by_zero), 0);
      chk("after_dbz quotient", int'(quotient), 4);

      // start held high: one done per operation, back-to-back period 2N+3
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 4'd3;
      ndone    = 0;
      first    = -1;
      second   = -1;
      for (int j = 1; j <= 22; j++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first < 0) first = j; else second = j;
            chk("held 50/3 quotient", int'(quotient), 16);
            chk("held 50/3 remainder", int'(remainder), 2);
         end
      end
      start = 1'b0;
      chk("held done_count", ndone, 2);
      chk("held period", second - first, 2 * N + 3);
      repeat (12) @(negedge clk);

      // reset at iteration 4 abandons the operation
      start    = 1'b1;
      dividend = 8'd200;
      divisor  = 4'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midreset quotient", int'(quotient), 0);
      chk("midreset remainder", int'(remainder), 0);
      chk("midreset busy", int'(busy), 0);
      chk("midreset done", int'(done), 0);
      chk("midreset dbz", int'(div_by_zero), 0);
      ndone = 0;
      for (int j = 0; j < 15; j++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      chk("midreset no_done", ndone, 0);
      run_op(8'd9, 4'd2, lat, rc);
      chk("9/2 quotient", int'(quotient), 4);
      chk("9/2 remainder", int'(remainder), 1);

      // every dividend/divisor pair; results checked by the model on the done cycle
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op((2*N)'(a), N'(b), lat, rc);
            chk("exhaustive latency", lat, (b == 0) ? 1 : 2 * N + 2);
         end
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
